// File: rtl/hv_pwm_intb_encode_pkg.sv
// Shared HV/LV parameters for the INTB pulse-width link: encoder FSM encoding,
// encoder timing defaults and the thresholds the LV-side decoder applies.
package hv_pwm_intb_encode_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2,
        ST_GUARD = 2'd3
    } hv_pwm_state_e;

    // Encoder timing defaults, in i_clk cycles.
    localparam int unsigned HV_PULSE_W_DEF     = 6;
    localparam int unsigned HV_GAP_W_DEF       = 4;
    localparam int unsigned HV_FRAME_GAP_DEF   = 16;
    localparam int unsigned HV_REFRESH_CYC_DEF = 1024;

    // Pulses per frame for each carried level.
    localparam int unsigned HV_PULSES_ASSERT   = 1;
    localparam int unsigned HV_PULSES_DEASSERT = 4;

    // LV decoder: accepted pulse width window, and the low run that closes a
    // frame (longer than any legal gap, shorter than the minimum guard).
    localparam int unsigned LV_PULSE_MIN    = 4;
    localparam int unsigned LV_PULSE_MAX    = 8;
    localparam int unsigned LV_FRAME_END_LO = 10;

    function automatic int unsigned hv_max3(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/hv_pwm_intb_encode.sv
// Encodes the HV interrupt level as a pulse-count frame on a single line:
// one pulse for asserted, four for deasserted, with optional periodic re-send.
module hv_pwm_intb_encode
    import hv_pwm_intb_encode_pkg::*;
#(
    parameter int unsigned PULSE_W     = HV_PULSE_W_DEF,
    parameter int unsigned GAP_W       = HV_GAP_W_DEF,
    parameter int unsigned FRAME_GAP   = HV_FRAME_GAP_DEF,
    parameter int unsigned REFRESH_CYC = HV_REFRESH_CYC_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_hv_intb_n,
    input  logic i_refresh_en,
    output logic o_hv_pwm_intb_n,
    output logic o_busy,
    output logic o_frame_done,
    output logic o_sent_intb_n
);

    localparam int unsigned CNT_MAX = hv_max3(PULSE_W, GAP_W, FRAME_GAP);
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned REF_W   = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;

    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_W - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(FRAME_GAP - 1);
    localparam logic [REF_W-1:0] REF_LAST   = REF_W'(REFRESH_CYC - 1);

    hv_pwm_state_e    state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [1:0]       pulse_cnt_reg, pulse_cnt_next;
    logic [REF_W-1:0] ref_cnt_reg, ref_cnt_next;
    logic             sent_reg, sent_next;
    logic             pwm_reg, pwm_next;

    logic             level_change;
    logic             refresh_due;
    logic             frame_start;
    logic [1:0]       pulse_last;

    always_comb begin
        level_change = (i_hv_intb_n != sent_reg);
        refresh_due  = i_refresh_en && (ref_cnt_reg == REF_LAST);
        // A coincident level change and refresh collapse into one frame,
        // which carries the new level because the input is latched.
        frame_start  = (state_reg == ST_IDLE) && (level_change || refresh_due);
        pulse_last   = sent_reg ? 2'(HV_PULSES_DEASSERT - 1)
                                : 2'(HV_PULSES_ASSERT - 1);
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        pulse_cnt_next = pulse_cnt_reg;
        ref_cnt_next   = ref_cnt_reg;
        sent_next      = sent_reg;

        case (state_reg)
            ST_IDLE: begin
                cnt_next = '0;
                if (frame_start) begin
                    state_next     = ST_PULSE;
                    sent_next      = i_hv_intb_n;
                    pulse_cnt_next = '0;
                    ref_cnt_next   = '0;
                end else if (i_refresh_en && (ref_cnt_reg != REF_LAST)) begin
                    ref_cnt_next = ref_cnt_reg + 1'b1;
                end
            end
            ST_PULSE: begin
                if (cnt_reg == PULSE_LAST) begin
                    cnt_next = '0;
                    if (pulse_cnt_reg == pulse_last) begin
                        state_next = ST_GUARD;
                    end else begin
                        state_next     = ST_GAP;
                        pulse_cnt_next = pulse_cnt_reg + 2'd1;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_reg == GAP_LAST) begin
                    cnt_next   = '0;
                    state_next = ST_PULSE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_GUARD: begin
                if (cnt_reg == GUARD_LAST) begin
                    cnt_next   = '0;
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next     = ST_IDLE;
                cnt_next       = '0;
                pulse_cnt_next = '0;
            end
        endcase

        if (!i_refresh_en) begin
            ref_cnt_next = '0;
        end

        // Registered line: high exactly while the next state is PULSE.
        pwm_next = (state_next == ST_PULSE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            pulse_cnt_reg <= '0;
            ref_cnt_reg   <= '0;
            sent_reg      <= 1'b1;
            pwm_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            pulse_cnt_reg <= pulse_cnt_next;
            ref_cnt_reg   <= ref_cnt_next;
            sent_reg      <= sent_next;
            pwm_reg       <= pwm_next;
        end
    end

    assign o_hv_pwm_intb_n = pwm_reg;
    assign o_busy          = (state_reg != ST_IDLE);
    assign o_frame_done    = (state_reg == ST_GUARD) && (cnt_reg == GUARD_LAST);
    assign o_sent_intb_n   = sent_reg;

endmodule
